// File: rtl/multibyte_serial_adder.sv
// Byte-serial add/subtract sequencer around an 8-bit carry-lookahead adder.
// Wide operands are latched on start and processed one byte per cycle, LSB byte first.

module eight_bit_look_ahead_carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);

  logic [7:0] g_s;
  logic [7:0] p_s;
  logic [8:0] c_s;
  logic       term_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Each carry is a flat sum-of-products of generate/propagate terms, not a ripple chain.
  always_comb begin
    c_s    = 9'd0;
    term_s = 1'b0;
    c_s[0] = c_in;
    for (int i = 0; i < 8; i++) begin
      term_s = c_in;
      for (int k = 0; k <= i; k++) begin
        term_s = term_s & p_s[k];
      end
      c_s[i+1] = term_s;
      for (int j = 0; j <= i; j++) begin
        term_s = g_s[j];
        for (int k = j + 1; k <= i; k++) begin
          term_s = term_s & p_s[k];
        end
        c_s[i+1] = c_s[i+1] | term_s;
      end
    end
  end

  assign sum   = p_s ^ c_s[7:0];
  assign c_out = c_s[8];

endmodule

module multibyte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic            accept_s;
  logic            last_s;
  logic [IDXW-1:0] idx_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            carry_r;
  logic [7:0]      a_byte_s;
  logic [7:0]      b_byte_s;
  logic [7:0]      sum_byte_s;
  logic            c_out_s;

  assign last_s = (idx_r == LAST_IDX);

  // Next-state decode; a start is only taken when the sequencer is IDLE or DONE.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = ADD;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADD: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ADD;
        end
      end
      DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = ADD;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register; status outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state_r  <= state_next_s;
      busy     <= (state_next_s == ADD);
      done     <= (state_next_s == DONE);
      in_ready <= (state_next_s == IDLE) || (state_next_s == DONE);
    end
  end

  // Byte slice selection for the current index.
  always_comb begin
    a_byte_s = 8'd0;
    b_byte_s = 8'd0;
    for (int k = 0; k < NBYTES; k++) begin
      a_byte_s = (idx_r == IDXW'(k)) ? a_r[8*k +: 8] : a_byte_s;
      b_byte_s = (idx_r == IDXW'(k)) ? b_r[8*k +: 8] : b_byte_s;
    end
  end

  eight_bit_look_ahead_carry_adder u_adder (
    .a     (a_byte_s),
    .b     (b_byte_s),
    .c_in  (carry_r),
    .sum   (sum_byte_s),
    .c_out (c_out_s)
  );

  // Operand latch on accept, then one sum byte per ADD cycle with the carry held between bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
      sum     <= {W{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : cin;
      idx_r   <= {IDXW{1'b0}};
    end else if (state_r == ADD) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (idx_r == IDXW'(k)) begin
          sum[8*k +: 8] <= sum_byte_s;
        end
      end
      carry_r <= c_out_s;
      if (last_s) begin
        cout  <= c_out_s;
        ovf   <= (a_r[W-1] ~^ b_r[W-1]) & (sum_byte_s[7] ^ a_r[W-1]);
        idx_r <= {IDXW{1'b0}};
      end else begin
        idx_r <= idx_r + 1'b1;
      end
    end
  end

endmodule
